// File: rtl/counter_pkg.sv
// +------------------------------------------------------------------+
// | counter_pkg: mode encodings and width helper for mod_counter     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_next.sv
// +------------------------------------------------------------------+
// | mod_counter_next: next-count and terminal detect for mod_counter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mod_counter_next
  import counter_pkg::*;
#(
  parameter int MOD = 8,
  parameter int W   = clog2w(MOD)
) (
  input  logic [W-1:0] q,
  input  logic         up,
  input  logic [1:0]   mode,
  output logic [W-1:0] q_next,
  output logic         term_evt
);

  localparam logic [W:0]   c_MOD = (W+1)'(MOD);
  localparam logic [W-1:0] c_TOP = W'(MOD - 1);

  logic [W:0]   w_inc;
  logic [W-1:0] w_dec;
  logic         w_hold;

  // Increment is one bit wider so reaching MOD is seen without W-bit rollover.
  assign w_inc  = {1'b0, q} + (W+1)'(1);
  assign w_dec  = q - W'(1);
  assign w_hold = (mode == MODE_SAT) || (mode == MODE_ONESHOT);

  always_comb begin
    q_next   = q;
    term_evt = 1'b0;
    if (up) begin
      if (w_inc >= c_MOD) begin
        term_evt = 1'b1;
        q_next   = w_hold ? q : '0;
      end else begin
        q_next = w_inc[W-1:0];
      end
    end else begin
      if (q == '0) begin
        term_evt = 1'b1;
        q_next   = w_hold ? q : c_TOP;
      end else begin
        q_next = w_dec;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// +------------------------------------------------------------------+
// | mod_counter: modulo-N up/down counter with load and terminal modes|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mod_counter
  import counter_pkg::*;
#(
  parameter int MOD     = 8,
  parameter int W       = clog2w(MOD),
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [1:0]   mode,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         ovf,
  output logic         done
);

  localparam logic [W:0]   c_MOD  = (W+1)'(MOD);
  localparam logic [W-1:0] c_TOP  = W'(MOD - 1);
  localparam logic [W-1:0] c_RSTV = W'(RST_VAL);

  logic [W-1:0] r_q;
  logic         r_tc;
  logic         r_ovf;
  logic         r_done;

  logic [W-1:0] w_q_next;
  logic         w_term;
  logic [W-1:0] w_load_q;
  logic         w_step;

  mod_counter_next #(
    .MOD (MOD),
    .W   (W)
  ) u_next (
    .q        (r_q),
    .up       (up),
    .mode     (mode),
    .q_next   (w_q_next),
    .term_evt (w_term)
  );

  // Out-of-range load values clamp to the top of the count range.
  assign w_load_q = ({1'b0, load_val} >= c_MOD) ? c_TOP : load_val;
  assign w_step   = en && !r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= c_RSTV;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_q;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else if (w_step) begin
      r_q  <= w_q_next;
      r_tc <= w_term;
      if (w_term) begin
        r_ovf <= 1'b1;
        if (mode == MODE_ONESHOT) r_done <= 1'b1;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign ovf  = r_ovf;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// +------------------------------------------------------------------+
// | tb_mod_counter: directed self-checking bench for mod_counter     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mod_counter;

  localparam int MOD = 10;
  localparam int W   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = 2'b00;

  logic [W-1:0] q_o    [2];
  logic         tc_o   [2];
  logic         ovf_o  [2];
  logic         done_o [2];

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  int mq    [2];
  bit mtc   [2];
  bit movf  [2];
  bit mdone [2];
  int rstv  [2] = '{0, 5};

  always #5 clk = ~clk;

  mod_counter #(.MOD(MOD), .W(W), .RST_VAL(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .mode(mode), .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .done(done_o[0])
  );

  mod_counter #(.MOD(MOD), .W(W), .RST_VAL(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .mode(mode), .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .done(done_o[1])
  );

  task automatic chk(input string nm, input int got, input int exp);
    total = total + 1;
    if (got != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = rstv[k]; mtc[k] = 0; movf[k] = 0; mdone[k] = 0;
    end
  endtask

  // Reference behaviour stated as plain arithmetic on integers.
  task automatic model_edge();
    int t;
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        mq[k] = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
        mtc[k] = 0; movf[k] = 0; mdone[k] = 0;
      end else if (en && !mdone[k]) begin
        t = up ? MOD - 1 : 0;
        if (mq[k] == t) begin
          mtc[k] = 1; movf[k] = 1;
          if (mode == 2'b10) mdone[k] = 1;
          else if (mode != 2'b01) mq[k] = up ? 0 : MOD - 1;
        end else begin
          mtc[k] = 0;
          mq[k] = up ? mq[k] + 1 : mq[k] - 1;
        end
      end else begin
        mtc[k] = 0;
      end
    end
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_edge();
  end

  always @(posedge clk) begin
    #1;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_q[%0d]", k),    int'(q_o[k]),    mq[k]);
        chk($sformatf("cyc_tc[%0d]", k),   int'(tc_o[k]),   int'(mtc[k]));
        chk($sformatf("cyc_ovf[%0d]", k),  int'(ovf_o[k]),  int'(movf[k]));
        chk($sformatf("cyc_done[%0d]", k), int'(done_o[k]), int'(mdone[k]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = W'(v);
    step(1);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int down_q [5]  = '{2, 1, 0, 9, 8};

    step(2);
    rst = 1'b0;
    chk("rst_q0", int'(q_o[0]), 0);
    chk("rst_q5", int'(q_o[1]), 5);
    chk("rst_flags", int'({tc_o[0], ovf_o[0], done_o[0]}), 0);
    armed = 1'b1;

    // Wrap up
    en = 1'b1; up = 1'b1; mode = 2'b00;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("wrap_up_q", int'(q_o[0]), wrap_q[i]);
      chk("wrap_up_tc", int'(tc_o[0]), (i == 9) ? 1 : 0);
    end
    chk("wrap_up_ovf", int'(ovf_o[0]), 1);

    // Wrap down
    up = 1'b0;
    do_load(3);
    chk("load3_q", int'(q_o[0]), 3);
    chk("load3_ovf", int'(ovf_o[0]), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("wrap_dn_q", int'(q_o[0]), down_q[i]);
      chk("wrap_dn_tc", int'(tc_o[0]), (i == 3) ? 1 : 0);
    end

    // Saturate
    mode = 2'b01; up = 1'b1;
    do_load(8);
    step(1);
    chk("sat_q9", int'(q_o[0]), 9);
    chk("sat_tc_first", int'(tc_o[0]), 0);
    step(3);
    chk("sat_q_hold", int'(q_o[0]), 9);
    chk("sat_tc_high", int'(tc_o[0]), 1);
    en = 1'b0;
    step(1);
    chk("sat_tc_drop", int'(tc_o[0]), 0);
    chk("sat_ovf", int'(ovf_o[0]), 1);

    // One-shot
    mode = 2'b10;
    do_load(7);
    en = 1'b1;
    step(2);
    chk("os_q9", int'(q_o[0]), 9);
    chk("os_done_pre", int'(done_o[0]), 0);
    step(1);
    chk("os_done", int'(done_o[0]), 1);
    chk("os_tc", int'(tc_o[0]), 1);
    step(5);
    chk("os_frozen", int'(q_o[0]), 9);
    chk("os_tc_quiet", int'(tc_o[0]), 0);
    do_load(2);
    chk("os_reload_q", int'(q_o[0]), 2);
    chk("os_reload_done", int'(done_o[0]), 0);
    chk("os_reload_ovf", int'(ovf_o[0]), 0);

    // Clamp, and load colliding with a terminal condition
    mode = 2'b00;
    do_load(15);
    chk("clamp_q", int'(q_o[0]), 9);
    chk("clamp_tc", int'(tc_o[0]), 0);
    do_load(4);
    chk("load_vs_term_q", int'(q_o[0]), 4);
    chk("load_vs_term_tc", int'(tc_o[0]), 0);
    chk("load_vs_term_ovf", int'(ovf_o[0]), 0);

    // Asynchronous reset mid-count
    do_load(6);
    step(1);
    chk("pre_rst_q", int'(q_o[1]), 7);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_q5", int'(q_o[1]), 5);
    chk("async_q0", int'(q_o[0]), 0);
    chk("async_flags", int'({tc_o[1], ovf_o[1], done_o[1]}), 0);
    #1;
    rst = 1'b0;
    en = 1'b1;
    step(1);
    chk("resume_q5", int'(q_o[1]), 6);
    chk("resume_q0", int'(q_o[0]), 1);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
